// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Used by both the receive and transmit blocks.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int CLKS_PER_BIT_DFLT = 104;
    localparam int HALF              = CLKS_PER_BIT_DFLT / 2;
    localparam int CNT_W             = $clog2(CLKS_PER_BIT_DFLT);

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle-high line resets to 1.
`timescale 1ns/1ps
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    // NOTE: clocked state always uses non-blocking assignment so both flops
    // sample the pre-edge values and the chain really is two stages deep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 with o_perr when UART_RX_PARITY_EN is defined.
// Start-bit glitch rejection, framing-error strobe and a BREAK state for a held-low line.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_ferr,
    output logic                 o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 o_perr
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_e          r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
    logic                 w_par_err;

    // Even parity: data bits plus parity bit must have an even number of ones.
    assign w_par_err = ^{r_shreg, r_par};
`endif

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                // Confirm the start bit at its centre; a short low pulse is a glitch.
                ST_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == C_LAST) begin
                        r_par   <= w_rx_s;
                        r_state <= ST_STOP;
                    end
                end
`endif

                // A low stop bit wins over a parity mismatch.
                ST_STOP: begin
                    if (r_cnt == C_LAST) begin
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (w_par_err) begin
                                r_perr <= 1'b1;
                            end else begin
                                r_data  <= r_shreg;
                                r_valid <= 1'b1;
                            end
`else
                            r_data  <= r_shreg;
                            r_valid <= 1'b1;
`endif
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end
                end

                ST_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_ferr  = r_ferr;
    assign o_busy  = r_busy;
`ifdef UART_RX_PARITY_EN
    assign o_perr  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven by a task, expected strobes
// are queued at stimulus time and popped by a monitor on every output strobe.
`timescale 1ns/100ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int    CPB    = CLKS_PER_BIT_DFLT;
    localparam int    BIT_NS = 8681;
    localparam int    CLK_NS = 83;
`ifdef UART_RX_PARITY_EN
    localparam int    LAT    = 2 + HALF + 9 * CPB + 1 + CPB;
`else
    localparam int    LAT    = 2 + HALF + 9 * CPB + 1;
`endif

    typedef enum logic [1:0] {EV_VALID, EV_FERR, EV_PERR} ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_ferr;
    logic       o_busy;
    logic       w_perr;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    always #41.5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_rx    (i_rx),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ferr  (o_ferr),
        .o_busy  (o_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_perr  (w_perr)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign w_perr = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_e kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // rst_bit >= 0 pulses reset 3/4 of the way through that data bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input int rst_bit);
        i_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            if (i == rst_bit) begin
                #(BIT_NS * 3 / 4);
                @(negedge clk);
                i_rst = 1'b1;
                @(negedge clk);
                i_rst = 1'b0;
                i_rx  = 1'b1;
                check("rst_mid_busy",  {31'd0, o_busy},  32'd0);
                check("rst_mid_valid", {31'd0, o_valid}, 32'd0);
                check("rst_mid_ferr",  {31'd0, o_ferr},  32'd0);
                check("rst_mid_data",  {24'd0, o_data},  32'd0);
                return;
            end
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^d) ^ par_flip;
        #(BIT_NS);
`else
        if (par_flip) i_rx = 1'b1;
`endif
        i_rx = stop_bit;
        #(BIT_NS);
        i_rx = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_valid || o_ferr || w_perr) begin
            ev_t  e;
            ev_e  act;
            act = o_ferr ? EV_FERR : (w_perr ? EV_PERR : EV_VALID);
            check("valid_ferr_exclusive", {31'd0, o_valid & o_ferr}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_kind", {30'd0, act}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {30'd0, act}, {30'd0, e.kind});
                check("event_data", {24'd0, o_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        int n;
        logic got;

        // Reset state
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        check("reset_busy",  {31'd0, o_busy},  32'd0);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_ferr",  {31'd0, o_ferr},  32'd0);
        check("reset_data",  {24'd0, o_data},  32'd0);
        #(5 * BIT_NS);

        // 1. AA, 00, 23 with 100-bit gaps; first frame also measures latency
        expect_ev(EV_VALID, 8'hAA);
        @(negedge clk);
        fork
            send_frame(8'hAA, 1'b1, 1'b0, -1);
            begin
                n   = 0;
                got = 1'b0;
                while (!got && n < LAT + 50) begin
                    @(posedge clk);
                    n++;
                    #1;
                    got = o_valid;
                end
                check("latency_edges", n, LAT + 1);
            end
        join
        #(100 * BIT_NS);
        expect_ev(EV_VALID, 8'h00);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        #(100 * BIT_NS);
        expect_ev(EV_VALID, 8'h23);
        send_frame(8'h23, 1'b1, 1'b0, -1);
        #(5 * BIT_NS);

        // 2. back-to-back 55, FF
        expect_ev(EV_VALID, 8'h55);
        expect_ev(EV_VALID, 8'hFF);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        #(5 * BIT_NS);

        // 3. 2 us start glitch
        @(negedge clk);
        i_rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", {31'd0, o_busy}, 32'd1);
        #(2000 - 4 * CLK_NS);
        i_rx = 1'b1;
        n = 0;
        while (o_busy && n < HALF + 3) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_drop", {31'd0, o_busy}, 32'd0);
        #(5 * BIT_NS);

        // 4. framing error, line held low 20 bits, then a good AA
        expect_ev(EV_FERR, 8'hFF);
        send_frame(8'h23, 1'b0, 1'b0, -1);
        i_rx = 1'b0;
        #(20 * BIT_NS);
        check("break_busy", {31'd0, o_busy}, 32'd1);
        i_rx = 1'b1;
        #(3 * BIT_NS);
        check("break_exit_busy", {31'd0, o_busy}, 32'd0);
        expect_ev(EV_VALID, 8'hAA);
        send_frame(8'hAA, 1'b1, 1'b0, -1);
        #(5 * BIT_NS);

        // 5. reset during bit 4 of AA, then 00
        send_frame(8'hAA, 1'b1, 1'b0, 4);
        #(5 * BIT_NS);
        expect_ev(EV_VALID, 8'h00);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        #(5 * BIT_NS);

`ifdef UART_RX_PARITY_EN
        // 6. 23 with good parity, then with bad parity
        expect_ev(EV_VALID, 8'h23);
        send_frame(8'h23, 1'b1, 1'b0, -1);
        #(5 * BIT_NS);
        expect_ev(EV_PERR, 8'h23);
        send_frame(8'h23, 1'b1, 1'b1, -1);
        #(5 * BIT_NS);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
